// File: rtl/mult_div_unit_pkg.sv
// Shared encodings for the execution-stage multiply/divide unit.
// The decoder imports the same MAD_sel values.
package mult_div_unit_pkg;

    localparam logic [2:0] MDU_MULT  = 3'd0;
    localparam logic [2:0] MDU_MULTU = 3'd1;
    localparam logic [2:0] MDU_DIV   = 3'd2;
    localparam logic [2:0] MDU_DIVU  = 3'd3;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } mdu_res_t;

endpackage

// File: rtl/mdu_arith.sv
// Combinational mult/multu/div/divu datapath.
// Signed divide works on magnitudes; the sign fix-up also covers 0x80000000 / -1.
module mdu_arith
    import mult_div_unit_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi_res,
    output logic [31:0] lo_res,
    output logic        div_by_zero
);

    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;
    logic [31:0]        a_mag;
    logic [31:0]        b_mag;
    logic [31:0]        sq;
    logic [31:0]        sr;
    logic [31:0]        uq;
    logic [31:0]        ur;

    always_comb begin
        prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        prod_u = {32'd0, a} * {32'd0, b};
        a_mag  = a[31] ? (32'd0 - a) : a;
        b_mag  = b[31] ? (32'd0 - b) : b;
        sq     = a_mag / b_mag;
        sr     = a_mag % b_mag;
        uq     = a / b;
        ur     = a % b;
        div_by_zero = 1'b0;
        hi_res = prod_s[63:32];
        lo_res = prod_s[31:0];
        case (op)
            MDU_MULTU: begin
                hi_res = prod_u[63:32];
                lo_res = prod_u[31:0];
            end
            MDU_DIV: begin
                div_by_zero = (b == 32'd0);
                lo_res = (a[31] ^ b[31]) ? (32'd0 - sq) : sq;
                hi_res = a[31] ? (32'd0 - sr) : sr;
            end
            MDU_DIVU: begin
                div_by_zero = (b == 32'd0);
                lo_res = uq;
                hi_res = ur;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide responder owning HI/LO.
// Result is computed at start and parked until the latency counter expires.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  MAD_sel,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        HI_En,
    input  logic        LO_En,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    logic [0:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    mdu_res_t      pend_q, pend_d;
    logic [31:0]   hi_q, hi_d;
    logic [31:0]   lo_q, lo_d;
    mdu_res_t      res;
    logic          is_div;

    mdu_arith u_arith (
        .op          (MAD_sel),
        .a           (A),
        .b           (B),
        .hi_res      (res.hi),
        .lo_res      (res.lo),
        .div_by_zero (res.dbz)
    );

    assign is_div = (MAD_sel == MDU_DIV) || (MAD_sel == MDU_DIVU);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    pend_d  = res;
                    cnt_d   = is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                    state_d = ST_RUN;
                end else begin
                    if (HI_En) hi_d = A;
                    if (LO_En) lo_d = A;
                end
            end
            default: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = ST_IDLE;
                    if (!pend_q.dbz) begin
                        hi_d = pend_q.hi;
                        lo_d = pend_q.lo;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pend_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy = (state_q == ST_RUN);
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule
